// File: rtl/utmi_link_bist.sv
// utmi_link_bist: UTMI pseudo-random packet generator with in-order loopback scoreboard.
// Transmitted bytes are queued and compared against returned bytes; errors and packets are counted.
module utmi_link_bist #(
  parameter int          LEN_W      = 4,
  parameter int          FIFO_DEPTH = 32,
  parameter int          IPG_CYCLES = 8,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic [7:0]       utmi_data_o,
  output logic             utmi_txvalid_o,
  input  logic             utmi_txready_i,
  input  logic [7:0]       utmi_data_i,
  input  logic             utmi_rxvalid_i,
  input  logic             utmi_rxactive_i,
  input  logic             utmi_rxerror_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] tx_pkts_o,
  output logic [CNT_W-1:0] rx_pkts_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(IPG_CYCLES + 1);
  localparam logic [AW:0] MAX_FILL = (AW+1)'(FIFO_DEPTH - (1 << LEN_W));
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(IPG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PID, DATA, GAP} state_t;

  state_t           state;
  logic [15:0]      lfsr, lfsr_nx;
  logic [LEN_W-1:0] len_r, rem;
  logic [GW-1:0]    gap_cnt;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt, cnt_nx;
  logic             start, accept, last, txv_nx;
  logic             pop_req, pop, push, pop_err, push_err, rx_err, rxactive_q;
  logic [1:0]       err_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    lfsr_nx  = lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
    start    = state == IDLE && enable_i && cnt <= MAX_FILL;
    accept   = utmi_txvalid_o && utmi_txready_i;
    last     = accept && (state == PID ? len_r == '0 : rem == LEN_W'(1));
    txv_nx   = start || (utmi_txvalid_o && !last);
    pop_req  = utmi_rxvalid_i && utmi_rxactive_i;
    pop      = pop_req && cnt != '0;
    pop_err  = pop_req && (cnt == '0 || mem[rd_ptr] != utmi_data_i);
    push     = accept && (cnt != FULL || pop);
    push_err = accept && !push;
    rx_err   = utmi_rxerror_i && utmi_rxactive_i;
    err_inc  = 2'(pop_err) + 2'(push_err) + 2'(rx_err);
    cnt_nx   = cnt + (AW+1)'(push) - (AW+1)'(pop);
  end

  // LFSR advances on the length draw and on every accepted byte, so data is lfsr[7:0] after each advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      lfsr           <= SEED;
      len_r          <= '0;
      rem            <= '0;
      gap_cnt        <= '0;
      utmi_data_o    <= '0;
      utmi_txvalid_o <= 1'b0;
    end else begin
      utmi_txvalid_o <= txv_nx;
      case (state)
        IDLE: if (start) begin
          len_r       <= lfsr[LEN_W-1:0];
          lfsr        <= lfsr_nx;
          utmi_data_o <= {~lfsr_nx[3:0], lfsr_nx[3:0]};
          state       <= PID;
        end
        PID: if (accept) begin
          lfsr        <= lfsr_nx;
          rem         <= len_r;
          utmi_data_o <= lfsr_nx[7:0];
          gap_cnt     <= '0;
          state       <= len_r == '0 ? GAP : DATA;
        end
        DATA: if (accept) begin
          lfsr        <= lfsr_nx;
          rem         <= rem - 1'b1;
          utmi_data_o <= lfsr_nx[7:0];
          gap_cnt     <= '0;
          state       <= last ? GAP : DATA;
        end
        default: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) if (push) mem[wr_ptr] <= utmi_data_o;

  // An empty FIFO never bypasses: a pop request against it is an underflow even if a push lands this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      busy_o     <= 1'b0;
      rxactive_q <= 1'b0;
      tx_pkts_o  <= '0;
      rx_pkts_o  <= '0;
      err_cnt_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt        <= cnt_nx;
      busy_o     <= txv_nx || cnt_nx != '0;
      rxactive_q <= utmi_rxactive_i;
      tx_pkts_o  <= clear_i ? '0 : sat_add(tx_pkts_o, {1'b0, last});
      rx_pkts_o  <= clear_i ? '0 : sat_add(rx_pkts_o, {1'b0, rxactive_q && !utmi_rxactive_i});
      err_cnt_o  <= clear_i ? '0 : sat_add(err_cnt_o, err_inc);
      err_o      <= !clear_i && (err_o || err_inc != '0);
    end
  end
endmodule

// File: tb/tb_utmi_link_bist.sv
// tb_utmi_link_bist: randomized loopback, corruption, underflow, gating, reset and saturation checks.
module tb_utmi_link_bist;
  localparam int LEN_W = 4;
  localparam int DEPTH = 16;
  localparam int IPG = 8;
  localparam int CNT_W = 8;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0, rst_ni = 1'b0, enable = 1'b0, clear = 1'b0, txready = 1'b0;
  logic rxvalid = 1'b0, rxactive = 1'b0, rxerror = 1'b0;
  logic [7:0] rxdata = 8'h00;
  logic [7:0] data_o;
  logic txvalid, busy, err;
  logic [CNT_W-1:0] tx_pkts, rx_pkts, err_cnt;

  utmi_link_bist #(.LEN_W(LEN_W), .FIFO_DEPTH(DEPTH), .IPG_CYCLES(IPG), .SEED(SEED), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable), .clear_i(clear),
    .utmi_data_o(data_o), .utmi_txvalid_o(txvalid), .utmi_txready_i(txready),
    .utmi_data_i(rxdata), .utmi_rxvalid_i(rxvalid), .utmi_rxactive_i(rxactive), .utmi_rxerror_i(rxerror),
    .busy_o(busy), .tx_pkts_o(tx_pkts), .rx_pkts_o(rx_pkts), .err_cnt_o(err_cnt), .err_o(err)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: packets as byte lists drawn from the LFSR, scoreboard as a queue.
  logic [15:0] m_lfsr;
  logic [7:0] cur_q[$];
  logic [7:0] sb[$];
  int m_tx, m_rx, m_err, e_m, tinc_m, acc, low_run, starts;
  bit m_flag, m_prev_act, in_pkt, strict, pid_seen;
  logic [7:0] first_pid;
  bit lb_en, bp_en, lb_v, lb_a;
  logic [7:0] lb_b;
  int lb_cnt, corrupt_at;

  function automatic logic [15:0] nx(input logic [15:0] x);
    return x[0] ? (x >> 1) ^ 16'hB400 : x >> 1;
  endfunction

  function automatic int sat(input int a, input int b);
    return (a + b > CMAX) ? CMAX : a + b;
  endfunction

  task automatic gen_pkt();
    int len;
    logic [7:0] pid_b;
    len = int'(m_lfsr) & ((1 << LEN_W) - 1);
    m_lfsr = nx(m_lfsr);
    pid_b = {~m_lfsr[3:0], m_lfsr[3:0]};
    cur_q.push_back(pid_b);
    m_lfsr = nx(m_lfsr);
    for (int i = 0; i < len; i++) begin
      cur_q.push_back(m_lfsr[7:0]);
      m_lfsr = nx(m_lfsr);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_ni) begin
      m_lfsr = SEED;
      cur_q.delete();
      sb.delete();
      m_tx = 0; m_rx = 0; m_err = 0; m_flag = 0; m_prev_act = 0;
      in_pkt = 0; low_run = 1000; pid_seen = 0;
      lb_v = 0; lb_a = 0; lb_b = 8'h00;
      check("rst_txvalid", txvalid, 0);
    end else begin
      check("tx_pkts", tx_pkts, m_tx);
      check("rx_pkts", rx_pkts, m_rx);
      check("err_cnt", err_cnt, m_err);
      check("err_flag", err, m_flag);
      if (!txvalid) check("busy", busy, sb.size() != 0);
      if (txvalid) begin
        if (!in_pkt) begin
          check("gap_min", low_run >= IPG + 1, 1);
          if (strict) check("gap", low_run, IPG + 1);
          gen_pkt();
          in_pkt = 1; acc = 0; starts++;
          if (!pid_seen) begin pid_seen = 1; first_pid = data_o; end
        end
        if (cur_q.size() == 0) check("eop_late", txvalid, 0);
        else check("tx_data", data_o, cur_q[0]);
        low_run = 0;
      end else begin
        low_run++;
        if (in_pkt) begin
          check("pkt_len", cur_q.size(), 0);
          cur_q.delete();
          in_pkt = 0;
        end
      end
      e_m = 0; tinc_m = 0;
      if (rxvalid && rxactive) begin
        if (sb.size() == 0) e_m++;
        else begin
          if (sb[0] !== rxdata) e_m++;
          void'(sb.pop_front());
        end
      end
      if (txvalid && txready && cur_q.size() != 0) begin
        sb.push_back(cur_q.pop_front());
        acc++;
        if (cur_q.size() == 0) tinc_m = 1;
      end
      if (rxerror && rxactive) e_m++;
      if (clear) begin
        m_tx = 0; m_rx = 0; m_err = 0; m_flag = 0;
      end else begin
        m_tx = sat(m_tx, tinc_m);
        m_rx = sat(m_rx, int'(m_prev_act && !rxactive));
        m_err = sat(m_err, e_m);
        m_flag = m_flag || e_m != 0;
      end
      m_prev_act = rxactive;
      lb_v = txvalid && txready; lb_a = txvalid; lb_b = data_o;
    end
  end

  // Loopback returns each accepted byte one cycle later, framed by the delayed txvalid.
  initial forever begin
    @(posedge clk); #1;
    if (lb_en) begin
      rxvalid = lb_v; rxactive = lb_a; rxdata = lb_b;
      if (lb_v) begin
        lb_cnt++;
        if (lb_cnt == corrupt_at) rxdata[0] = ~rxdata[0];
      end
    end
    if (bp_en) txready = 1'($urandom_range(0, 1));
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clear();
    clear = 1; tick(1); clear = 0;
  endtask

  task automatic drain(input string tag);
    int i = 0;
    while (busy && i < 500) begin tick(1); i++; end
    check(tag, busy, 0);
    tick(4);
  endtask

  task automatic wait_pid(input string tag);
    int i = 0;
    while (!pid_seen && i < 50) begin tick(1); i++; end
    check(tag, first_pid, 8'hF0);
  endtask

  task automatic return_all();
    logic [7:0] q[$];
    q = sb;
    foreach (q[i]) begin
      rxactive = 1; rxvalid = 1; rxdata = q[i];
      tick(1);
    end
    rxvalid = 0; rxactive = 0;
  endtask

  initial begin
    int i, s0;
    #(2_000_000);
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, s0;
    lb_cnt = 0; corrupt_at = 0; starts = 0; strict = 0;
    tick(3);
    check("rst_data", data_o, 0);
    check("rst_valid", txvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_cnts", {tx_pkts, rx_pkts, err_cnt}, 0);
    check("rst_err", err, 0);
    rst_ni = 1;

    // zero-latency loopback
    txready = 1; lb_en = 1; enable = 1;
    wait_pid("first_pid");
    s0 = starts;
    i = 0;
    while (starts == s0 && i < 100) begin tick(1); i++; end
    strict = 1;
    tick(2500);
    strict = 0; enable = 0;
    drain("lb_drain");
    check("lb_err", err_cnt, 0);
    check("lb_tx", tx_pkts, m_tx);
    check("lb_rx_vs_tx", rx_pkts, m_tx);
    check("lb_any", tx_pkts != 0, 1);

    // corruption of the 5th returned byte
    pulse_clear();
    lb_cnt = 0; corrupt_at = 5; enable = 1;
    tick(300);
    enable = 0;
    drain("cor_drain");
    check("cor_cnt", err_cnt, 1);
    check("cor_err", err, 1);
    pulse_clear();
    tick(1);
    check("clr_cnt", err_cnt, 0);
    check("clr_err", err, 0);
    corrupt_at = 0;

    // backpressure, enable dropped mid-DATA
    bp_en = 1; enable = 1;
    i = 0;
    while (!(in_pkt && acc >= 1 && cur_q.size() >= 2) && i < 2000) begin tick(1); i++; end
    check("bp_middata", in_pkt && acc >= 1 && cur_q.size() >= 2, 1);
    enable = 0;
    s0 = starts;
    i = 0;
    while (txvalid && i < 500) begin tick(1); i++; end
    check("bp_done", txvalid, 0);
    tick(100);
    check("bp_no_new", starts, s0);
    check("bp_txv", txvalid, 0);
    bp_en = 0; txready = 1;
    drain("bp_drain");

    // underflow with an empty FIFO
    lb_en = 0; rxvalid = 0; rxactive = 0;
    pulse_clear();
    rxdata = 8'h5A; rxactive = 1; rxvalid = 1;
    tick(5);
    rxvalid = 0; rxactive = 0;
    tick(2);
    check("uf_cnt", err_cnt, 5);
    check("uf_err", err, 1);
    check("uf_busy", busy, 0);
    check("uf_rx", rx_pkts, 1);

    // FIFO-full gating: one packet, then wait until it is returned
    pulse_clear();
    s0 = starts; enable = 1;
    i = 0;
    while (starts == s0 && i < 50) begin tick(1); i++; end
    i = 0;
    while (txvalid && i < 50) begin tick(1); i++; end
    tick(60);
    check("gate_one", starts - s0, 1);
    check("gate_txv", txvalid, 0);
    return_all();
    i = 0;
    while (starts == s0 + 1 && i < 30) begin tick(1); i++; end
    check("gate_resume", starts - s0, 2);
    enable = 0;
    i = 0;
    while (txvalid && i < 50) begin tick(1); i++; end
    return_all();
    tick(3);
    check("gate_err", err_cnt, 0);
    check("gate_busy", busy, 0);

    // reset mid-packet
    lb_en = 1; enable = 1;
    i = 0;
    while (!(in_pkt && acc >= 1 && cur_q.size() >= 2) && i < 2000) begin tick(1); i++; end
    @(posedge clk); #3;
    rst_ni = 0;
    #1 check("rst_async_txv", txvalid, 0);
    tick(2);
    check("rst_busy2", busy, 0);
    rst_ni = 1;
    wait_pid("pid_after_rst");
    tick(200);
    enable = 0;
    drain("rst_drain");

    // counter saturation
    lb_en = 0; rxvalid = 0; rxactive = 0;
    pulse_clear();
    rxdata = 8'h5A; rxactive = 1; rxvalid = 1;
    tick(CMAX + 45);
    rxvalid = 0; rxactive = 0;
    tick(2);
    check("sat_cnt", err_cnt, CMAX);
    check("sat_err", err, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
